multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have no parameters.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 Opcode  in  6  IR[31:26]; stable from DECODE until the next FETCH.
REQ-005 Funct  in  6  IR[5:0]; same stability as Opcode.
REQ-006 Zero  in  1  ALU zero flag; sampled only in BRANCH.
REQ-007 PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ShiftSrc, ZeroExt  out  1 each  datapath strobes and selects.
REQ-008 ALUSrcB  out  2  00=B reg, 01=const 4, 10=extended imm, 11=sign-ext imm<<2.
REQ-009 PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-010 ALUOperation  out  4  AND=0 OR=1 NOR=2 ADD=3 SUB=4 SLL=5 SRL=6 LUI=7 BEQ=8 BNE=9.
REQ-011 IllegalInstr  out  1  one-cycle pulse in DECODE for unsupported opcode/funct.

Function
REQ-012 SHALL be a Moore FSM; outputs are pure functions of state, Opcode and Funct, except PCWrite in BRANCH, which equals Zero.
REQ-013 States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BRANCH, JUMP.
REQ-014 Unlisted outputs SHALL be 0 in every state.
REQ-015 IDLE: all outputs 0; next FETCH.
REQ-016 FETCH: MemRead=1, IRWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOperation=ADD, PCSource=00, PCWrite=1; next DECODE.
REQ-017 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOperation=ADD. Next state: lw/sw(0x23/0x2B)->MEM_ADDR; R-type(0x00) with a supported funct->EXEC_R; addi/andi/ori/lui(0x08/0x0C/0x0D/0x0F)->EXEC_I; beq/bne(0x04/0x05)->BRANCH; j(0x02)->JUMP. Anything else: IllegalInstr=1, next FETCH.
REQ-018 Supported funct: add 0x20->ADD, sub 0x22->SUB, and 0x24->AND, or 0x25->OR, nor 0x27->NOR, sll 0x00->SLL, srl 0x02->SRL.
REQ-019 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOperation=ADD; next MEM_RD (lw) or MEM_WR (sw).
REQ-020 MEM_RD: IorD=1, MemRead=1; next MEM_WB. MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1; next FETCH.
REQ-021 MEM_WR: IorD=1, MemWrite=1; next FETCH.
REQ-022 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOperation per REQ-018; ShiftSrc=1 only for sll/srl; next ALU_WB.
REQ-023 EXEC_I: ALUSrcA=1, ALUSrcB=10; addi->ADD, andi->AND with ZeroExt=1, ori->OR with ZeroExt=1, lui->LUI; next ALU_WB.
REQ-024 ALU_WB: RegWrite=1, MemtoReg=0, RegDst=1 if Opcode=0x00, else 0; next FETCH.
REQ-025 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOperation=BEQ/BNE, PCSource=01, PCWrite=Zero; next FETCH.
REQ-026 JUMP: PCSource=10, PCWrite=1; next FETCH.
REQ-027 Latency from FETCH to the next FETCH: lw 5 cycles; R-type, I-ALU and sw 4; beq, bne and j 3; illegal 2.
REQ-028 Exactly one state SHALL be active per cycle; unreachable encodings SHALL go to IDLE.

Reset
REQ-029 reset low SHALL force IDLE immediately, without waiting for clk, and drive all outputs to 0, including mid-instruction.
REQ-030 After reset deasserts, first edge enters FETCH; no write strobe may assert before that FETCH.

Structure
REQ-031 Shared package SHALL hold opcode/funct constants, ALUOperation encodings (also used by the ALU) and the state enumeration.
REQ-032 Funct/opcode-to-ALUOperation mapping SHALL be a combinational sub-module, alu_op_decoder.

Verification
REQ-033 Release reset -> IDLE 1 cycle, then FETCH with MemRead=IRWrite=PCWrite=1 and ALUOperation=3.
REQ-034 Opcode=0x00, Funct=0x22 -> DECODE, EXEC_R with ALUOperation=4, ALU_WB with RegWrite=1, RegDst=1; FETCH after 4 cycles.
REQ-035 Opcode=0x23 -> MEM_ADDR, MEM_RD, then MEM_WB with MemtoReg=1; 5 cycles; Opcode=0x2B -> MemWrite=1, RegWrite never asserted.
REQ-036 Opcode=0x05, Zero=1 -> PCWrite=1, PCSource=01; repeat with Zero=0 -> PCWrite=0; 3 cycles each.
REQ-037 Opcode=0x3F -> IllegalInstr pulse in DECODE, then FETCH, no write strobes asserted.
REQ-038 Assert reset in MEM_RD during lw -> outputs 0 immediately; after release, IDLE then FETCH; RegWrite never asserted.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS-subset control unit.
// Holds opcode/funct constants, the ALUOperation encoding (shared with the
// ALU) and the control FSM state enumeration.
package multicycle_control_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;

    // ALUOperation encoding, also decoded by the ALU
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_NOR = 4'd2;
    localparam logic [3:0] ALU_ADD = 4'd3;
    localparam logic [3:0] ALU_SUB = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_LUI = 4'd7;
    localparam logic [3:0] ALU_BEQ = 4'd8;
    localparam logic [3:0] ALU_BNE = 4'd9;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_EXEC_R   = 4'd7,
        ST_EXEC_I   = 4'd8,
        ST_ALU_WB   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11
    } state_t;

endpackage

// File: rtl/multicycle_control_alu_op_decoder.sv
// alu_op_decoder: combinational opcode/funct -> ALUOperation mapping.
// Ports:
//   opcode   in  6  IR[31:26]
//   funct    in  6  IR[5:0]
//   alu_op   out 4  ALUOperation for EXEC_R / EXEC_I / BRANCH
//   funct_ok out 1  R-type funct is one of the supported set
//   shift    out 1  R-type funct is sll/srl (shamt feeds the ALU)
//   zero_ext out 1  immediate must be zero-extended (andi/ori)
module alu_op_decoder
    import multicycle_control_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       funct_ok,
    output logic       shift,
    output logic       zero_ext
);

    always_comb begin
        alu_op   = ALU_ADD;
        funct_ok = 1'b0;
        shift    = 1'b0;
        zero_ext = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                funct_ok = 1'b1;
                case (funct)
                    FN_ADD: alu_op = ALU_ADD;
                    FN_SUB: alu_op = ALU_SUB;
                    FN_AND: alu_op = ALU_AND;
                    FN_OR:  alu_op = ALU_OR;
                    FN_NOR: alu_op = ALU_NOR;
                    FN_SLL: begin alu_op = ALU_SLL; shift = 1'b1; end
                    FN_SRL: begin alu_op = ALU_SRL; shift = 1'b1; end
                    default: funct_ok = 1'b0;
                endcase
            end
            OP_ADDI: alu_op = ALU_ADD;
            OP_ANDI: begin alu_op = ALU_AND; zero_ext = 1'b1; end
            OP_ORI:  begin alu_op = ALU_OR;  zero_ext = 1'b1; end
            OP_LUI:  alu_op = ALU_LUI;
            OP_BEQ:  alu_op = ALU_BEQ;
            OP_BNE:  alu_op = ALU_BNE;
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for a multicycle MIPS-subset datapath.
// Ports:
//   clk, reset (async, active low)
//   Opcode, Funct  in  6 each  instruction fields, stable DECODE..next FETCH
//   Zero           in  1       ALU zero flag, only used in BRANCH
//   PCWrite..ZeroExt  out 1 each  datapath strobes and selects
//   ALUSrcB, PCSource out 2, ALUOperation out 4, IllegalInstr out 1
//   state          out 4       current FSM state (state_t encoding), debug
// Outputs are decoded from the state register only (plus Opcode/Funct), so
// an asynchronous reset into IDLE zeroes every output at once.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       ShiftSrc,
    output logic       ZeroExt,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] ALUOperation,
    output logic       IllegalInstr,
    output logic [3:0] state
);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] dec_alu_op;
    logic       dec_funct_ok;
    logic       dec_shift;
    logic       dec_zero_ext;

    alu_op_decoder u_alu_op_decoder (
        .opcode   (Opcode),
        .funct    (Funct),
        .alu_op   (dec_alu_op),
        .funct_ok (dec_funct_ok),
        .shift    (dec_shift),
        .zero_ext (dec_zero_ext)
    );

    assign state = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = ST_IDLE;
        PCWrite      = 1'b0;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        ShiftSrc     = 1'b0;
        ZeroExt      = 1'b0;
        ALUSrcB      = 2'b00;
        PCSource     = 2'b00;
        ALUOperation = 4'd0;
        IllegalInstr = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                MemRead      = 1'b1;
                IRWrite      = 1'b1;
                ALUSrcB      = 2'b01;
                ALUOperation = ALU_ADD;
                PCWrite      = 1'b1;
                state_d      = ST_DECODE;
            end
            ST_DECODE: begin
                // Branch target is precomputed here into ALUOut
                ALUSrcB      = 2'b11;
                ALUOperation = ALU_ADD;
                case (Opcode)
                    OP_LW, OP_SW:                    state_d = ST_MEM_ADDR;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = ST_EXEC_I;
                    OP_BEQ, OP_BNE:                  state_d = ST_BRANCH;
                    OP_J:                            state_d = ST_JUMP;
                    OP_RTYPE: begin
                        if (dec_funct_ok) begin
                            state_d = ST_EXEC_R;
                        end else begin
                            IllegalInstr = 1'b1;
                            state_d      = ST_FETCH;
                        end
                    end
                    default: begin
                        IllegalInstr = 1'b1;
                        state_d      = ST_FETCH;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                ALUOperation = ALU_ADD;
                if (Opcode == OP_LW)      state_d = ST_MEM_RD;
                else if (Opcode == OP_SW) state_d = ST_MEM_WR;
                else                      state_d = ST_FETCH;
            end
            ST_MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                state_d = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_EXEC_R: begin
                ALUSrcA      = 1'b1;
                ALUOperation = dec_alu_op;
                ShiftSrc     = dec_shift;
                state_d      = ST_ALU_WB;
            end
            ST_EXEC_I: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                ALUOperation = dec_alu_op;
                ZeroExt      = dec_zero_ext;
                state_d      = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                RegWrite = 1'b1;
                RegDst   = (Opcode == OP_RTYPE);
                state_d  = ST_FETCH;
            end
            ST_BRANCH: begin
                ALUSrcA      = 1'b1;
                ALUOperation = dec_alu_op;
                PCSource     = 2'b01;
                PCWrite      = Zero;
                state_d      = ST_FETCH;
            end
            ST_JUMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                state_d  = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle vector table plus a hand-written
// asynchronous-reset-during-lw sequence.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    logic       clk;
    logic       reset;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg;
    logic       RegWrite, ALUSrcA, ShiftSrc, ZeroExt, IllegalInstr;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] ALUOperation;
    logic [3:0] state;
    logic [19:0] act_out;

    int tests_run    = 0;
    int tests_failed = 0;

    multicycle_control dut (
        .clk          (clk),
        .reset        (reset),
        .Opcode       (Opcode),
        .Funct        (Funct),
        .Zero         (Zero),
        .PCWrite      (PCWrite),
        .IorD         (IorD),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .IRWrite      (IRWrite),
        .RegDst       (RegDst),
        .MemtoReg     (MemtoReg),
        .RegWrite     (RegWrite),
        .ALUSrcA      (ALUSrcA),
        .ShiftSrc     (ShiftSrc),
        .ZeroExt      (ZeroExt),
        .ALUSrcB      (ALUSrcB),
        .PCSource     (PCSource),
        .ALUOperation (ALUOperation),
        .IllegalInstr (IllegalInstr),
        .state        (state)
    );

    // Output bundle: pcw iord mrd mwr irw rdst m2r rw srca shift zext srcb pcsrc aop ill
    assign act_out = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
                      RegWrite, ALUSrcA, ShiftSrc, ZeroExt, ALUSrcB, PCSource,
                      ALUOperation, IllegalInstr};

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog run did not finish tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic [3:0]  st;
        logic [19:0] out;
    } vec_t;

    vec_t vecs[$];

    logic [19:0] e_zero, e_fetch, e_dec, e_dec_ill, e_maddr, e_mrd, e_mwb, e_mwr;
    logic [19:0] e_awb_r, e_awb_i, e_jump;

    function automatic logic [19:0] ob(input logic pcw, iord, mrd, mwr, irw, rdst,
                                       m2r, rw, srca, sh, zx, input logic [1:0] srcb,
                                       input logic [1:0] pcsrc, input logic [3:0] aop,
                                       input logic ill);
        return {pcw, iord, mrd, mwr, irw, rdst, m2r, rw, srca, sh, zx, srcb, pcsrc, aop, ill};
    endfunction

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic [3:0] st, input logic [19:0] out);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.st = st; v.out = out;
        vecs.push_back(v);
    endtask

    // R-type: FETCH, DECODE, EXEC_R, ALU_WB (4 cycles); Zero held at 1 to show it is ignored
    task automatic add_r(input logic [5:0] fn, input logic [3:0] aop, input logic sh);
        add(6'h00, fn, 1'b1, 4'd1, e_fetch);
        add(6'h00, fn, 1'b1, 4'd2, e_dec);
        add(6'h00, fn, 1'b1, 4'd7, ob(0,0,0,0,0,0,0,0,1,sh,0,2'b00,2'b00,aop,0));
        add(6'h00, fn, 1'b1, 4'd9, e_awb_r);
    endtask

    // I-type ALU: FETCH, DECODE, EXEC_I, ALU_WB (4 cycles); Funct is junk
    task automatic add_i(input logic [5:0] op, input logic [3:0] aop, input logic zx);
        add(op, 6'h22, 1'b0, 4'd1, e_fetch);
        add(op, 6'h22, 1'b0, 4'd2, e_dec);
        add(op, 6'h22, 1'b0, 4'd8, ob(0,0,0,0,0,0,0,0,1,0,zx,2'b10,2'b00,aop,0));
        add(op, 6'h22, 1'b0, 4'd9, e_awb_i);
    endtask

    // Branch: FETCH, DECODE, BRANCH (3 cycles)
    task automatic add_b(input logic [5:0] op, input logic [3:0] aop, input logic z);
        add(op, 6'h00, z, 4'd1, e_fetch);
        add(op, 6'h00, z, 4'd2, e_dec);
        add(op, 6'h00, z, 4'd10, ob(z,0,0,0,0,0,0,0,1,0,0,2'b00,2'b01,aop,0));
    endtask

    // ---------------- scoreboard check ----------------
    task automatic check(input string name, input int idx, input logic [19:0] act,
                         input logic [19:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- main test ----------------
    initial begin
        e_zero    = '0;
        e_fetch   = ob(1,0,1,0,1,0,0,0,0,0,0,2'b01,2'b00,4'd3,0);
        e_dec     = ob(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,4'd3,0);
        e_dec_ill = ob(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,4'd3,1);
        e_maddr   = ob(0,0,0,0,0,0,0,0,1,0,0,2'b10,2'b00,4'd3,0);
        e_mrd     = ob(0,1,1,0,0,0,0,0,0,0,0,2'b00,2'b00,4'd0,0);
        e_mwb     = ob(0,0,0,0,0,0,1,1,0,0,0,2'b00,2'b00,4'd0,0);
        e_mwr     = ob(0,1,0,1,0,0,0,0,0,0,0,2'b00,2'b00,4'd0,0);
        e_awb_r   = ob(0,0,0,0,0,1,0,1,0,0,0,2'b00,2'b00,4'd0,0);
        e_awb_i   = ob(0,0,0,0,0,0,0,1,0,0,0,2'b00,2'b00,4'd0,0);
        e_jump    = ob(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b10,4'd0,0);

        // IDLE for one cycle after reset release
        add(6'h00, 6'h20, 1'b0, 4'd0, e_zero);
        add_r(6'h22, 4'd4, 1'b0);   // sub
        add_r(6'h20, 4'd3, 1'b0);   // add
        add_r(6'h24, 4'd0, 1'b0);   // and
        add_r(6'h25, 4'd1, 1'b0);   // or
        add_r(6'h27, 4'd2, 1'b0);   // nor
        add_r(6'h00, 4'd5, 1'b1);   // sll
        add_r(6'h02, 4'd6, 1'b1);   // srl
        add_i(6'h08, 4'd3, 1'b0);   // addi
        add_i(6'h0C, 4'd0, 1'b1);   // andi
        add_i(6'h0D, 4'd1, 1'b1);   // ori
        add_i(6'h0F, 4'd7, 1'b0);   // lui
        // lw: 5 cycles
        add(6'h23, 6'h00, 1'b0, 4'd1, e_fetch);
        add(6'h23, 6'h00, 1'b0, 4'd2, e_dec);
        add(6'h23, 6'h00, 1'b0, 4'd3, e_maddr);
        add(6'h23, 6'h00, 1'b0, 4'd4, e_mrd);
        add(6'h23, 6'h00, 1'b0, 4'd5, e_mwb);
        // sw: 4 cycles, RegWrite stays 0 throughout
        add(6'h2B, 6'h00, 1'b0, 4'd1, e_fetch);
        add(6'h2B, 6'h00, 1'b0, 4'd2, e_dec);
        add(6'h2B, 6'h00, 1'b0, 4'd3, e_maddr);
        add(6'h2B, 6'h00, 1'b0, 4'd6, e_mwr);
        add_b(6'h05, 4'd9, 1'b1);   // bne taken
        add_b(6'h05, 4'd9, 1'b0);   // bne not taken
        add_b(6'h04, 4'd8, 1'b1);   // beq taken
        add_b(6'h04, 4'd8, 1'b0);   // beq not taken
        // j: 3 cycles
        add(6'h02, 6'h00, 1'b0, 4'd1, e_fetch);
        add(6'h02, 6'h00, 1'b0, 4'd2, e_dec);
        add(6'h02, 6'h00, 1'b0, 4'd11, e_jump);
        // illegal opcode and unsupported R-type funct: 2 cycles each
        add(6'h3F, 6'h00, 1'b0, 4'd1, e_fetch);
        add(6'h3F, 6'h00, 1'b0, 4'd2, e_dec_ill);
        add(6'h00, 6'h21, 1'b0, 4'd1, e_fetch);
        add(6'h00, 6'h21, 1'b0, 4'd2, e_dec_ill);

        // Reset phase: outputs zero and IDLE while held
        reset = 1'b0; Opcode = '0; Funct = '0; Zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_state", 0, {16'd0, state}, {16'd0, 4'd0});
        check("reset_out", 0, act_out, e_zero);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            Opcode = vecs[i].op;
            Funct  = vecs[i].fn;
            Zero   = vecs[i].z;
            #1;
            check("vec_state", i, {16'd0, state}, {16'd0, vecs[i].st});
            check("vec_out", i, act_out, vecs[i].out);
            step();
        end

        // Async reset asserted in MEM_RD of a lw
        Opcode = 6'h23; Funct = 6'h00; Zero = 1'b0;
        #1;
        check("lwrst_fetch", 0, {16'd0, state}, {16'd0, 4'd1});
        step();
        step();
        step();
        #1;
        check("lwrst_memrd", 0, act_out, e_mrd);
        #2;
        reset = 1'b0;
        #1;
        check("lwrst_async_state", 0, {16'd0, state}, {16'd0, 4'd0});
        check("lwrst_async_out", 0, act_out, e_zero);
        for (int k = 0; k < 2; k++) begin
            step();
            check("lwrst_hold_out", k, act_out, e_zero);
        end
        reset = 1'b1;
        #1;
        check("lwrst_idle", 0, {16'd0, state}, {16'd0, 4'd0});
        check("lwrst_idle_out", 0, act_out, e_zero);
        step();
        check("lwrst_fetch2_state", 0, {16'd0, state}, {16'd0, 4'd1});
        check("lwrst_fetch2_out", 0, act_out, e_fetch);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
